// File: rtl/control_unit_seq.sv
// rtl/control_unit_seq.sv - registered control unit: opcode decode, memory stall handshake, sticky fault flags
module control_unit_seq #(
    parameter int OP_WIDTH      = 8,
    parameter int ALUOP_WIDTH   = 3,
    parameter int ENABLE_MEM    = 1,
    parameter int ENABLE_SHIFT  = 1,
    parameter int STALL_TIMEOUT = 0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [OP_WIDTH-1:0]    OP,
    input  logic                   INSTR_VALID,
    input  logic                   BUSYWAIT,
    output logic [ALUOP_WIDTH-1:0] ALUOP,
    output logic                   MUX_2SCMPL,
    output logic                   MUX_IMMD,
    output logic                   WRITEENABLE,
    output logic                   BEQ_ENABLE,
    output logic                   BNE_ENABLE,
    output logic                   JUMP_ENABLE,
    output logic                   MEM_READ,
    output logic                   MEM_WRITE,
    output logic                   MUX_MEMDATA,
    output logic                   PC_HOLD,
    output logic                   ILLEGAL_OP,
    output logic                   MEM_TIMEOUT
);

    localparam int CW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] STALL_MAX = CW'(STALL_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_MEM
    } state_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic       cmpl;
        logic       immd;
        logic       we;
        logic       beq;
        logic       bne;
        logic       jump;
        logic       mrd;
        logic       mwr;
        logic       memdata;
    } ctrl_t;

    state_t         state_q, state_d;
    ctrl_t          ctrl_q, ctrl_d;
    ctrl_t          dec;
    logic           dec_illegal;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           illegal_q, illegal_d;
    logic           timeout_q, timeout_d;
    logic           advance;
    logic [OP_WIDTH+31:0] op_ext;

    // Zero-extend so narrow opcode widths still compare against the full table.
    assign op_ext = {32'd0, OP};

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        if (op_ext[OP_WIDTH+31:4] != '0) begin
            dec_illegal = 1'b1;
        end else begin
            case (op_ext[3:0])
                4'd0:  begin dec.immd = 1'b1; dec.we = 1'b1; end
                4'd1:  begin dec.we = 1'b1; end
                4'd2:  begin dec.aluop = 3'b001; dec.we = 1'b1; end
                4'd3:  begin dec.aluop = 3'b001; dec.cmpl = 1'b1; dec.we = 1'b1; end
                4'd4:  begin dec.aluop = 3'b010; dec.we = 1'b1; end
                4'd5:  begin dec.aluop = 3'b011; dec.we = 1'b1; end
                4'd6:  begin dec.aluop = 3'b111; dec.jump = 1'b1; end
                4'd7:  begin dec.aluop = 3'b001; dec.cmpl = 1'b1; dec.beq = 1'b1; end
                4'd12: begin dec.aluop = 3'b001; dec.cmpl = 1'b1; dec.bne = 1'b1; end
                4'd8, 4'd9: begin
                    if (ENABLE_MEM != 0) begin
                        dec.immd    = op_ext[0];
                        dec.mrd     = 1'b1;
                        dec.memdata = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                4'd10, 4'd11: begin
                    if (ENABLE_MEM != 0) begin
                        dec.immd = op_ext[0];
                        dec.mwr  = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                4'd13, 4'd14: begin
                    if (ENABLE_SHIFT != 0) begin
                        dec.aluop = op_ext[0] ? 3'b100 : 3'b101;
                        dec.immd  = 1'b1;
                        dec.we    = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        advance   = 1'b0;
        case (state_q)
            S_IDLE: advance = INSTR_VALID;
            S_RUN:  advance = 1'b1;
            S_MEM: begin
                if (BUSYWAIT) begin
                    if (cnt_q != STALL_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if ((STALL_TIMEOUT > 0) && (cnt_d == STALL_MAX)) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // An accepted slot either decodes the next opcode or inserts a bubble.
        if (advance) begin
            if (INSTR_VALID) begin
                ctrl_d    = dec;
                illegal_d = illegal_q | dec_illegal;
                state_d   = (dec.mrd || dec.mwr) ? S_MEM : S_RUN;
            end else begin
                ctrl_d  = '0;
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign ALUOP       = ALUOP_WIDTH'(ctrl_q.aluop);
    assign MUX_2SCMPL  = ctrl_q.cmpl;
    assign MUX_IMMD    = ctrl_q.immd;
    // Loads write back on the edge that completes the access.
    assign WRITEENABLE = (state_q == S_MEM) ? (ctrl_q.mrd & ~BUSYWAIT) : ctrl_q.we;
    assign BEQ_ENABLE  = ctrl_q.beq;
    assign BNE_ENABLE  = ctrl_q.bne;
    assign JUMP_ENABLE = ctrl_q.jump;
    assign MEM_READ    = ctrl_q.mrd;
    assign MEM_WRITE   = ctrl_q.mwr;
    assign MUX_MEMDATA = ctrl_q.memdata;
    assign PC_HOLD     = (state_q == S_IDLE) || ((state_q == S_MEM) && BUSYWAIT);
    assign ILLEGAL_OP  = illegal_q;
    assign MEM_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_control_unit_seq.sv
// tb/tb_control_unit_seq.sv - directed bench for control_unit_seq (default and timeout/no-shift variants)
module tb_control_unit_seq;

    logic       CLK;
    logic       RESET;
    logic [7:0] OP;
    logic       INSTR_VALID;
    logic       BUSYWAIT;

    logic [2:0] a_aluop, b_aluop;
    logic a_cmpl, a_immd, a_we, a_beq, a_bne, a_jump, a_mrd, a_mwr, a_mdata, a_hold, a_ill, a_tmo;
    logic b_cmpl, b_immd, b_we, b_beq, b_bne, b_jump, b_mrd, b_mwr, b_mdata, b_hold, b_ill, b_tmo;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    control_unit_seq u_dut_a (
        .CLK(CLK), .RESET(RESET), .OP(OP), .INSTR_VALID(INSTR_VALID), .BUSYWAIT(BUSYWAIT),
        .ALUOP(a_aluop), .MUX_2SCMPL(a_cmpl), .MUX_IMMD(a_immd), .WRITEENABLE(a_we),
        .BEQ_ENABLE(a_beq), .BNE_ENABLE(a_bne), .JUMP_ENABLE(a_jump), .MEM_READ(a_mrd),
        .MEM_WRITE(a_mwr), .MUX_MEMDATA(a_mdata), .PC_HOLD(a_hold), .ILLEGAL_OP(a_ill),
        .MEM_TIMEOUT(a_tmo)
    );

    control_unit_seq #(.ENABLE_SHIFT(0), .STALL_TIMEOUT(4)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .OP(OP), .INSTR_VALID(INSTR_VALID), .BUSYWAIT(BUSYWAIT),
        .ALUOP(b_aluop), .MUX_2SCMPL(b_cmpl), .MUX_IMMD(b_immd), .WRITEENABLE(b_we),
        .BEQ_ENABLE(b_beq), .BNE_ENABLE(b_bne), .JUMP_ENABLE(b_jump), .MEM_READ(b_mrd),
        .MEM_WRITE(b_mwr), .MUX_MEMDATA(b_mdata), .PC_HOLD(b_hold), .ILLEGAL_OP(b_ill),
        .MEM_TIMEOUT(b_tmo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RESET = 1'b1; OP = 8'h00; INSTR_VALID = 1'b0; BUSYWAIT = 1'b0;
        #12;
        chk("rst_aluop", a_aluop, 3'b000);
        chk("rst_we", a_we, 1'b0);
        chk("rst_hold", a_hold, 1'b1);
        chk("rst_ill", a_ill, 1'b0);
        chk("rst_mrd", a_mrd, 1'b0);

        RESET = 1'b0; OP = 8'h03; INSTR_VALID = 1'b1; #1;
        chk("pre_we", a_we, 1'b0);
        chk("pre_hold", a_hold, 1'b1);
        tick(); #1;
        chk("sub_aluop", a_aluop, 3'b001);
        chk("sub_cmpl", a_cmpl, 1'b1);
        chk("sub_we", a_we, 1'b1);
        chk("sub_hold", a_hold, 1'b0);

        OP = 8'h08;
        tick();
        OP = 8'hFF; BUSYWAIT = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("lwd_mrd", a_mrd, 1'b1);
            chk("lwd_hold", a_hold, 1'b1);
            chk("lwd_we_stall", a_we, 1'b0);
            chk("lwd_mdata", a_mdata, 1'b1);
            tick(); #1;
        end
        OP = 8'h02; BUSYWAIT = 1'b0; #1;
        chk("lwd_we_done", a_we, 1'b1);
        chk("lwd_hold_done", a_hold, 1'b0);
        chk("lwd_mrd_done", a_mrd, 1'b1);
        tick(); #1;
        chk("add_mrd", a_mrd, 1'b0);
        chk("add_aluop", a_aluop, 3'b001);
        chk("add_cmpl", a_cmpl, 1'b0);
        chk("add_mdata", a_mdata, 1'b0);
        chk("add_ill", a_ill, 1'b0);
        chk("b_no_tmo_3", b_tmo, 1'b0);

        OP = 8'h0A;
        tick();
        OP = 8'h09; #1;
        chk("swd_mwr", a_mwr, 1'b1);
        chk("swd_mrd", a_mrd, 1'b0);
        chk("swd_we", a_we, 1'b0);
        chk("swd_hold", a_hold, 1'b0);
        tick();
        OP = 8'h01; #1;
        chk("lwi_mrd", a_mrd, 1'b1);
        chk("lwi_mwr", a_mwr, 1'b0);
        chk("lwi_mdata", a_mdata, 1'b1);
        chk("lwi_immd", a_immd, 1'b1);
        chk("lwi_we", a_we, 1'b1);
        tick(); #1;
        chk("mov_we", a_we, 1'b1);
        chk("mov_immd", a_immd, 1'b0);
        chk("mov_mrd", a_mrd, 1'b0);

        OP = 8'h0D;
        tick(); #1;
        chk("sll_aluop", a_aluop, 3'b100);
        chk("sll_immd", a_immd, 1'b1);
        chk("sll_we", a_we, 1'b1);
        chk("sll_ill", a_ill, 1'b0);
        chk("b_sll_ill", b_ill, 1'b1);
        chk("b_sll_we", b_we, 1'b0);
        chk("b_sll_aluop", b_aluop, 3'b000);
        OP = 8'h0E;
        tick(); #1;
        chk("srl_aluop", a_aluop, 3'b101);

        INSTR_VALID = 1'b0;
        tick(); #1;
        chk("bub_we", a_we, 1'b0);
        chk("bub_aluop", a_aluop, 3'b000);
        chk("bub_hold", a_hold, 1'b0);

        INSTR_VALID = 1'b1; OP = 8'h07;
        tick(); #1;
        chk("beq_en", a_beq, 1'b1);
        chk("beq_cmpl", a_cmpl, 1'b1);
        OP = 8'h0C;
        tick(); #1;
        chk("bne_en", a_bne, 1'b1);
        chk("bne_beq", a_beq, 1'b0);
        chk("bne_we", a_we, 1'b0);
        OP = 8'h06;
        tick(); #1;
        chk("j_en", a_jump, 1'b1);
        chk("j_bne", a_bne, 1'b0);
        chk("j_aluop", a_aluop, 3'b111);
        OP = 8'hFF;
        tick(); #1;
        chk("ill_flag", a_ill, 1'b1);
        chk("ill_jump", a_jump, 1'b0);
        chk("ill_aluop", a_aluop, 3'b000);
        chk("ill_hold", a_hold, 1'b0);
        OP = 8'h00;
        tick(); #1;
        chk("ill_sticky", a_ill, 1'b1);
        chk("ldi_we", a_we, 1'b1);
        chk("ldi_immd", a_immd, 1'b1);

        OP = 8'h08;
        tick();
        BUSYWAIT = 1'b1; INSTR_VALID = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #1;
        chk("b_tmo_3", b_tmo, 1'b0);
        tick(); #1;
        chk("b_tmo_4", b_tmo, 1'b1);
        chk("b_tmo_mrd", b_mrd, 1'b1);
        chk("b_tmo_hold", b_hold, 1'b1);
        chk("a_no_tmo", a_tmo, 1'b0);
        tick(); #1;
        chk("b_tmo_sticky", b_tmo, 1'b1);

        RESET = 1'b1; #1;
        chk("arst_tmo", b_tmo, 1'b0);
        chk("arst_ill", b_ill, 1'b0);
        chk("arst_mrd", b_mrd, 1'b0);
        chk("arst_hold", b_hold, 1'b1);
        chk("arst_we", b_we, 1'b0);
        chk("arst_a_ill", a_ill, 1'b0);
        RESET = 1'b0; BUSYWAIT = 1'b0; INSTR_VALID = 1'b1; OP = 8'h05;
        tick(); #1;
        chk("or_aluop", a_aluop, 3'b011);
        chk("or_hold", b_hold, 1'b0);
        OP = 8'h04;
        tick(); #1;
        chk("and_aluop", a_aluop, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
